// File: rtl/xor_stream_descrambler.sv
// Receive-side XOR descrambler: unmasks a valid/ready word stream with a 16-bit LFSR
// keystream reseeded on each start-of-frame, with frame-sync hunting and an over-length guard.
module xor_stream_descrambler #(
  parameter int unsigned W       = 8,
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int unsigned MAX_LEN = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_sof,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_sof,
  output logic [15:0]  drop_cnt,
  output logic         overrun
);

  typedef enum logic {
    HUNT = 1'b0,
    SYNC = 1'b1
  } state_t;

  localparam logic [15:0] MAX_CNT = 16'(MAX_LEN);

  state_t         state_q, state_d;
  logic [15:0]    lfsr_q, lfsr_d;
  logic [15:0]    word_cnt_q, word_cnt_d;
  logic [15:0]    drop_cnt_q, drop_cnt_d;
  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   out_data_q, out_data_d;
  logic           out_sof_q, out_sof_d;
  logic           overrun_q, overrun_d;

  logic           accept;
  logic [15:0]    ks_state;
  logic [W-1:0]   ks_mask;
  logic [W-1:0]   unmasked;

  // A stalled output slot blocks input; no dependency on in_valid.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Step the LFSR W times from SEED (new frame) or the stored state, collecting
  // one keystream bit per data bit, LSB first; ks_state ends as the advanced state.
  always_comb begin
    ks_state = in_sof ? SEED : lfsr_q;
    ks_mask  = '0;
    for (int i = 0; i < int'(W); i++) begin
      ks_mask[i] = ks_state[15];
      ks_state   = {ks_state[14:0], ks_state[15] ^ ks_state[13] ^ ks_state[12] ^ ks_state[10]};
    end
  end

  assign unmasked = in_data ^ ks_mask;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    word_cnt_d  = word_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sof_d   = out_sof_q;
    overrun_d   = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      unique case (state_q)
        HUNT: begin
          if (in_sof) begin
            out_valid_d = 1'b1;
            out_data_d  = unmasked;
            out_sof_d   = 1'b1;
            lfsr_d      = ks_state;
            word_cnt_d  = 16'd1;
            state_d     = SYNC;
          end else if (drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
          end
        end
        SYNC: begin
          out_valid_d = 1'b1;
          out_data_d  = unmasked;
          out_sof_d   = in_sof;
          lfsr_d      = ks_state;
          if (in_sof) begin
            word_cnt_d = 16'd1;
          end else begin
            word_cnt_d = word_cnt_q + 16'd1;
            // The word reaching the limit is still delivered; the frame is then abandoned.
            if (word_cnt_q + 16'd1 == MAX_CNT) begin
              overrun_d = 1'b1;
              state_d   = HUNT;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      lfsr_q      <= SEED;
      word_cnt_q  <= 16'd0;
      drop_cnt_q  <= 16'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sof_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      word_cnt_q  <= word_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sof_q   <= out_sof_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sof   = out_sof_q;
  assign drop_cnt  = drop_cnt_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/xor_stream_descrambler.md
# xor_stream_descrambler

Receive-side counterpart of the XOR data-masking path: recovers plaintext words from a stream masked with a 16-bit LFSR keystream. The keystream is reseeded at every start-of-frame. The block sits between the link receiver and the consumer on a valid/ready stream. It adds one register stage, frame-sync tracking and an over-length frame guard.

## Interface
- W, 8: data word width in bits (1..32).
- SEED, 16'hACE1: LFSR seed loaded on each accepted start-of-frame; must be nonzero.
- MAX_LEN, 256: maximum number of words per frame, including the SOF word (2..65535).
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block accepts the input word this cycle.
- in_data  in  W  masked data word.
- in_sof  in  1  the current input word is the first word of a frame.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts the output word.
- out_data  out  W  unmasked data word.
- out_sof  out  1  the output word is the first word of a frame.
- drop_cnt  out  16  number of words discarded while unsynchronised; saturates at 16'hFFFF.
- overrun  out  1  one-cycle pulse when a frame reaches MAX_LEN words.

## Operation
- Handshakes:
  - An input word is accepted when in_valid && in_ready.
  - An output word is transferred when out_valid && out_ready.
- LFSR state s[15:0], advanced one step at a time:
  - keystream bit k = s[15];
  - fb = s[15]^s[13]^s[12]^s[10];
  - s <= {s[14:0], fb}.
- Per accepted synced word:
  - bit i (LSB first, i = 0..W-1) uses the keystream bit from step i;
  - out_data[i] = in_data[i] ^ k_i;
  - the stored LFSR state advances W steps.
- If in_sof is set on an accepted word, the keystream for that word starts from SEED, not from the stored state.
- State machine:
  - HUNT (reset state): accepted words with in_sof=0 are discarded and drop_cnt increments, saturating. An accepted word with in_sof=1 is unmasked, emitted with out_sof=1, sets word_cnt=1 and moves to SYNC.
  - SYNC: every accepted word is unmasked and emitted.
    - in_sof=1: reseed, word_cnt=1, out_sof=1.
    - Otherwise: word_cnt increments, out_sof=0.
    - If the accepted word brings word_cnt to MAX_LEN, pulse overrun on the next cycle and go to HUNT. That word itself is still emitted.
- Discarded words never produce out_valid.
- drop_cnt is cleared only by rst.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_sof=0;
  - drop_cnt=0, overrun=0;
  - state=HUNT, LFSR=SEED, word_cnt=0.
- in_ready = !out_valid || out_ready. This is combinational from out_ready; there is no combinational path from in_valid to in_ready.
- Latency: a word accepted in cycle N appears on out_* in cycle N+1.
- Throughput: one word per cycle when out_ready=1.
- Output hold: while out_valid && !out_ready, out_data and out_sof hold stable and in_ready=0.
- Simultaneous transfer: an output transfer and an input acceptance in the same cycle load the new word with no bubble.
- A discarded word in HUNT is accepted under the same in_ready rule but leaves out_valid unchanged.
- rst asserted mid-frame or mid-stall:
  - all state returns to reset values on the next edge;
  - a pending output word is lost;
  - the next frame must begin with in_sof.
- in_sof on the word that would reach MAX_LEN: it is treated as a new frame (word_cnt=1) and overrun does not pulse.

## Test plan
- **Basic unmask:** W=8, SEED=16'hACE1; send in_data=8'h00 with in_sof=1, out_ready=1. Expect out_data=8'h35 and out_sof=1 one cycle later; stored LFSR becomes 16'hE1E4. Repeat with in_data=8'h35, in_sof=1: expect 8'h00.
- **Hunt discard:** after reset, send 3 words with in_sof=0. Expect out_valid stays 0 and drop_cnt=3. A following sof word is emitted with out_sof=1.
- **Backpressure:** hold out_ready=0 for 4 cycles with in_valid=1. Expect in_ready=0 after the first accept and out_data stable throughout. Release out_ready: expect every word delivered once, in order, with correct data.
- **Overrun:** MAX_LEN=4; send a sof word plus 4 non-sof words. Expect 4 words emitted, a one-cycle overrun pulse, and the 5th word discarded with drop_cnt=1.
- **Resync mid-frame:** send sof, 2 words, then sof again with data 8'h00. Expect the second sof word's output to be 8'h35 (LFSR reseeded).
- **Reset during stall:** with out_valid=1 and out_ready=0, assert rst for 1 cycle. Expect out_valid=0, drop_cnt=0 and state HUNT: a non-sof word is then dropped.
